hdmi_crc_monitor: RTL and testbench

Passive per-channel CRC-32 monitor for the HDMI output AXI-Stream. It taps the video stream between the pixel pipeline and the HDMI encoder and checks frame geometry against SCREEN_WIDTH × SCREEN_HEIGHT. It computes one CRC per colour channel per frame and compares each frame against a programmable golden value. It also reports when output has been stable (identical CRCs) for a configurable number of consecutive frames.

---
 rtl/hdmi_crc_monitor_if.sv | 14 +
 rtl/hdmi_crc_monitor.sv | 163 ++++++++++++++++
 tb/tb_hdmi_crc_monitor.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hdmi_crc_monitor_if.sv
// Tapped AXI-Stream pixel bus between the pixel pipeline and the HDMI encoder.
// The monitor only observes it, so its modport is input-only.
interface hdmi_crc_monitor_if #(
  parameter int DATA_W = 24
) ();
  logic [DATA_W-1:0] mon_tdata;
  logic              mon_tvalid;
  logic              mon_tready;
  logic              mon_tlast;
  logic              mon_tuser;

  modport master (output mon_tdata, mon_tvalid, mon_tready, mon_tlast, mon_tuser);
  modport slave  (input  mon_tdata, mon_tvalid, mon_tready, mon_tlast, mon_tuser);
endinterface

// File: rtl/hdmi_crc_monitor.sv
// Passive per-channel CRC-32 frame monitor with geometry checking, golden compare
// and a stable-output detector for the HDMI output stream.
module hdmi_crc_monitor #(
  parameter int DATA_W        = 24,
  parameter int CHANNELS      = 3,
  parameter int CH_W          = 8,
  parameter int SCREEN_WIDTH  = 32,
  parameter int SCREEN_HEIGHT = 24,
  parameter int STABLE_FRAMES = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  hdmi_crc_monitor_if.slave       mon,
  input  logic                    enable_i,
  input  logic                    clear_i,
  input  logic [32*CHANNELS-1:0]  golden_crc_i,
  input  logic                    golden_valid_i,
  output logic [32*CHANNELS-1:0]  crc_last_o,
  output logic                    crc_valid_o,
  output logic [31:0]             frame_count_o,
  output logic [15:0]             mismatch_count_o,
  output logic [15:0]             geom_err_count_o,
  output logic                    stable_o,
  output logic [15:0]             line_count_o,
  output logic [15:0]             pixel_in_line_o
);

  localparam logic [31:0] CRC_POLY  = 32'hEDB8_8320;
  localparam logic [31:0] CRC_INIT  = 32'hFFFF_FFFF;
  localparam logic [15:0] LAST_PIX  = 16'(SCREEN_WIDTH - 1);
  localparam logic [15:0] LAST_LINE = 16'(SCREEN_HEIGHT - 1);
  localparam int          RUN_W     = (STABLE_FRAMES < 1) ? 1 : $clog2(STABLE_FRAMES + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STABLE_FRAMES);

  typedef enum logic {S_IDLE = 1'b0, S_ACTIVE = 1'b1} state_t;

  function automatic logic [31:0] crc_fold(input logic [31:0] crc, input logic [CH_W-1:0] d);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < CH_W; i++) begin
      c = (c[0] ^ d[i]) ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

  function automatic logic [15:0] sat_add16(input logic [15:0] v, input logic [1:0] inc);
    logic [16:0] s;
    s = {1'b0, v} + {15'd0, inc};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  state_t                      state_q;
  logic [CHANNELS-1:0][31:0]   crc_q, crc_d, crc_final;
  logic [CHANNELS-1:0][31:0]   crc_last_q;
  logic [15:0]                 pix_q, pix_d, pix_cur;
  logic [15:0]                 line_q, line_d, line_cur;
  logic                        err_q, err_d, err_cur;
  logic                        crc_valid_q, stable_q;
  logic [31:0]                 frame_q;
  logic [15:0]                 mism_q, geom_q;
  logic [RUN_W-1:0]            run_q, run_d, run_base;
  logic [DATA_W-1:0]           tdata;
  logic                        accept, start, beat, abort, close;
  logic                        same_crc, golden_miss;
  logic [1:0]                  geom_inc;

  assign tdata = mon.mon_tdata;

  always_comb begin
    accept   = mon.mon_tvalid & mon.mon_tready & enable_i;
    start    = accept & mon.mon_tuser;
    beat     = accept & (start | (state_q == S_ACTIVE));
    abort    = start & (state_q == S_ACTIVE);
    // A start-of-frame beat is processed as beat 0 of line 0 of a fresh frame.
    pix_cur  = start ? 16'd0 : pix_q;
    line_cur = start ? 16'd0 : line_q;
    err_cur  = start ? 1'b0  : err_q;
    if (mon.mon_tlast) begin
      err_d  = err_cur | (pix_cur != LAST_PIX);
      pix_d  = 16'd0;
      line_d = line_cur + 16'd1;
    end else begin
      err_d  = err_cur | (pix_cur >= LAST_PIX);
      pix_d  = pix_cur + 16'd1;
      line_d = line_cur;
    end
    close = beat & mon.mon_tlast & (line_cur == LAST_LINE);
    for (int c = 0; c < CHANNELS; c++) begin
      crc_d[c]     = crc_fold(start ? CRC_INIT : crc_q[c], tdata[c*CH_W +: CH_W]);
      crc_final[c] = ~crc_d[c];
    end
    // crc_last doubles as the previous-frame CRC: both are written on close and cleared together.
    same_crc    = (crc_final == crc_last_q);
    golden_miss = golden_valid_i & (crc_final != golden_crc_i);
    geom_inc    = {1'b0, abort} + {1'b0, close & err_d};
    run_base    = abort ? '0 : run_q;
    if (close && !err_d && same_crc) begin
      run_d = (run_base == RUN_MAX) ? RUN_MAX : run_base + 1'b1;
    end else if (close) begin
      run_d = '0;
    end else begin
      run_d = run_base;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      crc_q       <= '0;
      crc_last_q  <= '0;
      pix_q       <= 16'd0;
      line_q      <= 16'd0;
      err_q       <= 1'b0;
      crc_valid_q <= 1'b0;
      frame_q     <= 32'd0;
      mism_q      <= 16'd0;
      geom_q      <= 16'd0;
      run_q       <= '0;
      stable_q    <= 1'b0;
    end else if (clear_i) begin
      state_q     <= S_IDLE;
      crc_last_q  <= '0;
      crc_valid_q <= 1'b0;
      frame_q     <= 32'd0;
      mism_q      <= 16'd0;
      geom_q      <= 16'd0;
      run_q       <= '0;
      stable_q    <= 1'b0;
    end else if (!enable_i) begin
      state_q     <= S_IDLE;
      crc_valid_q <= 1'b0;
    end else begin
      crc_valid_q <= close;
      if (beat) begin
        crc_q   <= crc_d;
        pix_q   <= pix_d;
        line_q  <= line_d;
        err_q   <= err_d;
        state_q <= close ? S_IDLE : S_ACTIVE;
      end
      if (close) begin
        crc_last_q <= crc_final;
        frame_q    <= frame_q + 32'd1;
        if (!err_d && golden_miss) begin
          mism_q <= sat_add16(mism_q, 2'd1);
        end
      end
      geom_q   <= sat_add16(geom_q, geom_inc);
      run_q    <= run_d;
      stable_q <= (run_d == RUN_MAX);
    end
  end

  assign crc_last_o       = crc_last_q;
  assign crc_valid_o      = crc_valid_q;
  assign frame_count_o    = frame_q;
  assign mismatch_count_o = mism_q;
  assign geom_err_count_o = geom_q;
  assign stable_o         = stable_q;
  assign line_count_o     = line_q;
  assign pixel_in_line_o  = pix_q;

endmodule

// File: tb/tb_hdmi_crc_monitor.sv
// Self-checking bench: randomized stream gaps against a frame-level reference model
// using a table-driven CRC-32 and per-frame bookkeeping.
module tb_hdmi_crc_monitor;
  localparam int W  = 32;
  localparam int H  = 24;
  localparam int SF = 3;

  logic        clk = 1'b0;
  logic        rst, enable, clear, golden_valid;
  logic [95:0] golden;
  always #5 clk = ~clk;

  hdmi_crc_monitor_if #(.DATA_W(24)) mif ();
  hdmi_crc_monitor_if #(.DATA_W(24)) sif ();

  logic [95:0] crc_last, s_crc_last;
  logic        crc_valid, s_crc_valid, stable, s_stable;
  logic [31:0] frame_count, s_frame_count;
  logic [15:0] mism, geom, line_cnt, pix_cnt, s_mism, s_geom, s_line, s_pix;

  hdmi_crc_monitor dut (
    .clk(clk), .rst(rst), .mon(mif), .enable_i(enable), .clear_i(clear),
    .golden_crc_i(golden), .golden_valid_i(golden_valid),
    .crc_last_o(crc_last), .crc_valid_o(crc_valid), .frame_count_o(frame_count),
    .mismatch_count_o(mism), .geom_err_count_o(geom), .stable_o(stable),
    .line_count_o(line_cnt), .pixel_in_line_o(pix_cnt));

  hdmi_crc_monitor #(.SCREEN_WIDTH(1), .SCREEN_HEIGHT(1)) dut_s (
    .clk(clk), .rst(rst), .mon(sif), .enable_i(enable), .clear_i(clear),
    .golden_crc_i(golden), .golden_valid_i(golden_valid),
    .crc_last_o(s_crc_last), .crc_valid_o(s_crc_valid), .frame_count_o(s_frame_count),
    .mismatch_count_o(s_mism), .geom_err_count_o(s_geom), .stable_o(s_stable),
    .line_count_o(s_line), .pixel_in_line_o(s_pix));

  typedef struct {
    logic [23:0] d;
    logic        last;
    logic        user;
  } beat_t;

  beat_t       frame_q[$];
  logic [31:0] crc_tbl [256];
  int          checks = 0, errors = 0;
  int          n_pulse = 0, n_pulse_s = 0;
  int          m_pulses = 0, m_frames = 0, m_mism = 0, m_geom = 0, m_run = 0;
  logic [95:0] m_prev = '0, m_crc = '0, exp_crc;

  always @(negedge clk) if (crc_valid) n_pulse++;
  always @(negedge clk) if (s_crc_valid) n_pulse_s++;

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [95:0] frame_crc();
    logic [95:0] r;
    logic [31:0] c;
    logic [7:0]  b;
    for (int ch = 0; ch < 3; ch++) begin
      c = 32'hFFFF_FFFF;
      foreach (frame_q[i]) begin
        b = frame_q[i].d[ch*8 +: 8];
        c = crc_tbl[c[7:0] ^ b] ^ (c >> 8);
      end
      r[ch*32 +: 32] = ~c;
    end
    return r;
  endfunction

  // Gradient frame; optional short line, optional flipped pixel, optional truncation.
  task automatic build(input int bad_line, input int bad_len, input int mod_x, input int mod_y,
                       input int limit);
    frame_q.delete();
    for (int y = 0; y < H; y++) begin
      int len;
      len = (y == bad_line) ? bad_len : W;
      for (int x = 0; x < len; x++) begin
        beat_t b;
        b.d = {8'(x * 5 + y), 8'(y * 7), 8'(x ^ y)};
        if (x == mod_x && y == mod_y) b.d[15:8] = ~b.d[15:8];
        b.last = (x == len - 1);
        b.user = (x == 0 && y == 0);
        frame_q.push_back(b);
      end
    end
    while (frame_q.size() > limit) frame_q.delete(frame_q.size() - 1);
  endtask

  task automatic send(input bit clr_last);
    foreach (frame_q[i]) begin
      while ($urandom_range(0, 3) == 0) begin
        mif.mon_tvalid = 1'($urandom);
        mif.mon_tready = mif.mon_tvalid ? 1'b0 : 1'($urandom);
        mif.mon_tdata  = 24'($urandom);
        mif.mon_tlast  = 1'($urandom);
        mif.mon_tuser  = 1'($urandom);
        tick();
      end
      mif.mon_tdata  = frame_q[i].d;
      mif.mon_tvalid = 1'b1;
      mif.mon_tready = 1'b1;
      mif.mon_tlast  = frame_q[i].last;
      mif.mon_tuser  = frame_q[i].user;
      clear = clr_last && (i == frame_q.size() - 1);
      tick();
      clear = 1'b0;
    end
    mif.mon_tvalid = 1'b0;
  endtask

  task automatic model_close(input logic [95:0] c, input bit err);
    m_pulses++;
    m_frames++;
    m_crc = c;
    if (err) begin
      m_geom++;
      m_run = 0;
    end else begin
      if (golden_valid && c != golden) m_mism++;
      m_run = (c == m_prev) ? ((m_run < SF) ? m_run + 1 : SF) : 0;
    end
    m_prev = c;
  endtask

  task automatic model_clear();
    m_frames = 0; m_mism = 0; m_geom = 0; m_run = 0; m_prev = '0; m_crc = '0;
  endtask

  task automatic check_frame(input string tag);
    check({tag, "_valid"}, crc_valid, 1);
    check({tag, "_crc"}, crc_last, m_crc);
    check({tag, "_frames"}, frame_count, m_frames);
    check({tag, "_mism"}, mism, m_mism);
    check({tag, "_geom"}, geom, m_geom);
    check({tag, "_stable"}, stable, (m_run == SF));
    tick();
    check({tag, "_valid_low"}, crc_valid, 0);
    check({tag, "_pulses"}, n_pulse, m_pulses);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_crc"}, crc_last, 0);
    check({tag, "_valid"}, crc_valid, 0);
    check({tag, "_frames"}, frame_count, 0);
    check({tag, "_mism"}, mism, 0);
    check({tag, "_geom"}, geom, 0);
    check({tag, "_stable"}, stable, 0);
    check({tag, "_line"}, line_cnt, 0);
    check({tag, "_pix"}, pix_cnt, 0);
  endtask

  initial begin
    for (int n = 0; n < 256; n++) begin
      logic [31:0] v;
      v = 32'(n);
      for (int k = 0; k < 8; k++) v = v[0] ? ((v >> 1) ^ 32'hEDB8_8320) : (v >> 1);
      crc_tbl[n] = v;
    end
    rst = 1'b1; enable = 1'b1; clear = 1'b0; golden_valid = 1'b0; golden = '0;
    mif.mon_tvalid = 1'b0; mif.mon_tready = 1'b0; mif.mon_tdata = '0;
    mif.mon_tlast = 1'b0; mif.mon_tuser = 1'b0;
    sif.mon_tvalid = 1'b0; sif.mon_tready = 1'b0; sif.mon_tdata = '0;
    sif.mon_tlast = 1'b0; sif.mon_tuser = 1'b0;
    repeat (3) tick();
    check_reset("reset");
    rst = 1'b0;
    tick();

    // 1x1 screen: single zero beat closes a frame.
    sif.mon_tvalid = 1'b1; sif.mon_tready = 1'b1; sif.mon_tlast = 1'b1; sif.mon_tuser = 1'b1;
    tick();
    sif.mon_tvalid = 1'b0;
    check("tiny_crc", s_crc_last, {3{32'hD202_EF8D}});
    check("tiny_valid", s_crc_valid, 1);
    check("tiny_frames", s_frame_count, 1);
    tick();
    check("tiny_pulses", n_pulse_s, 1);

    // Five identical gradient frames build up the stable run.
    build(-1, 0, -1, -1, W * H);
    exp_crc = frame_crc();
    for (int f = 0; f < 5; f++) begin
      send(1'b0);
      check("grad_stable_plan", stable, (f >= 3));
      model_close(exp_crc, 1'b0);
      check_frame("grad");
    end

    // Golden compare with channel 1 wrong.
    clear = 1'b1;
    tick();
    clear = 1'b0;
    model_clear();
    check("clear_frames", frame_count, 0);
    check("clear_stable", stable, 0);
    golden = exp_crc ^ {32'd0, 32'h0000_0001, 32'd0};
    golden_valid = 1'b1;
    for (int f = 0; f < 5; f++) begin
      send(1'b0);
      check("gold_mism_plan", mism, f + 1);
      model_close(exp_crc, 1'b0);
      check_frame("gold");
    end
    build(-1, 0, 7, 5, W * H);
    send(1'b0);
    check("modpix_stable_drop", stable, 0);
    model_close(frame_crc(), 1'b0);
    check_frame("modpix");

    // Line 3 ends early: geometry error, no golden compare.
    build(3, 31, -1, -1, W * H);
    send(1'b0);
    model_close(frame_crc(), 1'b1);
    check("early_geom_plan", geom, 1);
    check_frame("early");
    build(-1, 0, -1, -1, W * H);
    send(1'b0);
    model_close(exp_crc, 1'b0);
    check_frame("after_early");

    // tuser mid-frame at line 10 aborts the frame.
    build(-1, 0, -1, -1, 10 * W + 5);
    send(1'b0);
    check("partial_line", line_cnt, 10);
    check("partial_pix", pix_cnt, 5);
    build(-1, 0, -1, -1, W * H);
    send(1'b0);
    m_geom++;
    m_run = 0;
    model_close(exp_crc, 1'b0);
    check("abort_geom_plan", geom, 2);
    check_frame("abort");

    // clear on the closing beat suppresses the close.
    send(1'b1);
    model_clear();
    check("clrlast_valid", crc_valid, 0);
    check("clrlast_crc", crc_last, 0);
    check("clrlast_frames", frame_count, 0);
    check("clrlast_mism", mism, 0);
    check("clrlast_geom", geom, 0);
    tick();
    check("clrlast_pulses", n_pulse, m_pulses);

    // Asynchronous reset mid-frame.
    build(-1, 0, -1, -1, 100);
    send(1'b0);
    rst = 1'b1;
    tick();
    check_reset("midrst");
    check("midrst_pulses", n_pulse, m_pulses);
    rst = 1'b0;
    model_clear();
    tick();
    build(-1, 0, -1, -1, W * H);
    send(1'b0);
    model_close(exp_crc, 1'b0);
    check_frame("post_rst");

    // Dropping enable discards the in-flight frame silently.
    build(-1, 0, -1, -1, 200);
    send(1'b0);
    enable = 1'b0;
    tick();
    enable = 1'b1;
    build(-1, 0, -1, -1, W * H);
    send(1'b0);
    model_close(exp_crc, 1'b0);
    check_frame("en_drop");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
